tbu_lifo: RTL and testbench

Output reordering stage of the Viterbi decoder, directly downstream of the traceback unit. The traceback unit emits decoded bits newest-first as a serial stream qualified by a write enable (`wr_en`), one window per high interval. This block captures each window into one of two ping-pong bit banks. It replays each captured window oldest-first as a valid-qualified serial stream with an end-of-window marker, so capture of the next window overlaps replay of the previous one.

---
 rtl/tbu_lifo.sv | 157 +++++++++++++++
 tb/tb_tbu_lifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tbu_lifo.sv
// Viterbi traceback output reorder: ping-pong capture of newest-first windows,
// replayed oldest-first with valid/last qualifiers.
module tbu_lifo #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  input  logic wr_en,
  output logic d_out,
  output logic d_valid,
  output logic d_last,
  output logic overflow,
  output logic busy
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_FILL = 2'd1, W_BLOCK = 2'd2} wstate_e;
  typedef enum logic       {R_IDLE = 1'b0, R_POP = 1'b1} rstate_e;

  localparam logic [AW:0] WPTR_END = DEPTH[AW:0];

  wstate_e                   wstate_q, wstate_d;
  rstate_e                   rstate_q, rstate_d;
  logic [1:0][DEPTH-1:0]     bank_q, bank_d;
  logic [1:0][AW:0]          len_q, len_d;
  logic [1:0]                full_q, full_d;
  logic                      wsel_q, wsel_d;
  logic                      rsel_q, rsel_d;
  logic [AW:0]               wptr_q, wptr_d;
  logic [AW-1:0]             rptr_q, rptr_d;
  logic                      wr_en_q;
  logic                      ovf_q, ovf_d;
  logic                      d_out_q, d_out_d;
  logic                      d_valid_q, d_valid_d;
  logic                      d_last_q, d_last_d;
  logic                      close_edge;
  logic [AW:0]               len_m1;

  assign close_edge = wr_en_q & ~wr_en;
  assign len_m1     = len_q[rsel_q] - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      len_q     <= '0;
      full_q    <= '0;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      wr_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
      d_out_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_last_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      len_q     <= len_d;
      full_q    <= full_d;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      wr_en_q   <= wr_en;
      ovf_q     <= ovf_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      d_last_q  <= d_last_d;
    end
  end

  // Bank contents need no reset; stale bits are never replayed past len.
  always_ff @(posedge clk) bank_q <= bank_d;

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (wr_en) wstate_d = full_q[wsel_q] ? W_BLOCK : W_FILL;
      W_FILL:  if (close_edge) wstate_d = W_IDLE;
      W_BLOCK: if (!wr_en) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (full_q[rsel_q]) rstate_d = R_POP;
      R_POP:   if (rptr_q == '0) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Capture and replay only ever touch different banks' full flags, so the
  // two case blocks below can share full_d without ordering concerns.
  always_comb begin
    bank_d    = bank_q;
    len_d     = len_q;
    full_d    = full_q;
    wsel_d    = wsel_q;
    rsel_d    = rsel_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ovf_d     = 1'b0;
    d_out_d   = 1'b0;
    d_valid_d = 1'b0;
    d_last_d  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (wr_en) begin
          if (full_q[wsel_q]) begin
            ovf_d = 1'b1;
          end else begin
            bank_d[wsel_q][0] = d_in;
            wptr_d            = {{AW{1'b0}}, 1'b1};
          end
        end
      end
      W_FILL: begin
        if (close_edge) begin
          len_d[wsel_q]  = wptr_q;
          full_d[wsel_q] = 1'b1;
          wsel_d         = ~wsel_q;
        end else if (wptr_q == WPTR_END) begin
          ovf_d = 1'b1;
        end else begin
          bank_d[wsel_q][wptr_q[AW-1:0]] = d_in;
          wptr_d                         = wptr_q + 1'b1;
        end
      end
      W_BLOCK: if (wr_en) ovf_d = 1'b1;
      default: ;
    endcase
    case (rstate_q)
      R_IDLE: if (full_q[rsel_q]) rptr_d = len_m1[AW-1:0];
      R_POP: begin
        d_out_d   = bank_q[rsel_q][rptr_q];
        d_valid_d = 1'b1;
        d_last_d  = (rptr_q == '0);
        if (rptr_q == '0) begin
          full_d[rsel_q] = 1'b0;
          rsel_d         = ~rsel_q;
        end else begin
          rptr_d = rptr_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign d_out    = d_out_q;
  assign d_valid  = d_valid_q;
  assign d_last   = d_last_q;
  assign overflow = ovf_q;
  assign busy     = (wstate_q != W_IDLE) | full_q[0] | full_q[1] | d_valid_q;

endmodule

// File: tb/tb_tbu_lifo.sv
// Directed bench for tbu_lifo: bit order, timing, ping-pong, overflow, blocking, reset.
module tb_tbu_lifo;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_in = 1'b0;
  logic wr_en = 1'b0;
  logic d_out, d_valid, d_last, overflow, busy;

  int vecs = 0, miss = 0, cyc = 0, ovf = 0, bad_last = 0;
  logic oq[$];
  int   cq[$];
  int   lq[$];

  tbu_lifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .wr_en(wr_en),
    .d_out(d_out), .d_valid(d_valid), .d_last(d_last),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; samples outputs 1 time unit later and logs the stream.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (d_valid === 1'b1) begin
      oq.push_back(d_out);
      cq.push_back(cyc);
      if (d_last === 1'b1) lq.push_back(oq.size() - 1);
    end else if (d_last !== 1'b0) begin
      bad_last++;
    end
    if (overflow === 1'b1) ovf++;
  endtask

  task automatic clear_log();
    oq.delete(); cq.delete(); lq.delete();
    ovf = 0; bad_last = 0;
  endtask

  task automatic send_window(input int n, input logic [127:0] bits, output int e);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; d_in = bits[i];
      step();
    end
    wr_en = 1'b0; d_in = 1'b0;
    step();
    e = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (busy === 1'b1 || d_valid === 1'b1); i++) step();
    chk("drain_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_window(input string tag, input int base, input int n, input logic [127:0] bits);
    for (int k = 0; k < n; k++)
      if (base + k < oq.size())
        chk($sformatf("%s[%0d]", tag, k), {31'b0, oq[base+k]}, {31'b0, bits[n-1-k]});
  endtask

  initial begin
    int e, ea, eb;
    logic w1_out[8];
    logic [127:0] pa, pb, po, p1, p2, p3, pm;
    w1_out = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pa = 128'h2C5;
    pb = 128'hA3E;
    po = 128'h5_D1B2_C3A4_9F86_E071;
    p1 = 128'h0F39_A5C6_B2DE_8174;
    p2 = 128'hD;
    p3 = 128'h0ABC_DEF0_1234_5678;
    pm = 128'hC6;

    // Reset with random traffic
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'($urandom_range(0, 1)); d_in = 1'($urandom_range(0, 1));
      step();
    end
    chk("rst_d_out", {31'b0, d_out}, 32'd0);
    chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
    chk("rst_d_last", {31'b0, d_last}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    wr_en = 1'b0; d_in = 1'b0; rst = 1'b0;
    step();
    chk("release_busy", {31'b0, busy}, 32'd0);
    chk("release_valid", {31'b0, d_valid}, 32'd0);

    // Single window 1,0,1,1,0,0,0,1
    clear_log();
    send_window(8, 128'h8D, e);
    chk("single_busy_at_E", {31'b0, busy}, 32'd1);
    drain();
    chk("single_count", oq.size(), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < oq.size()) chk($sformatf("single_bit[%0d]", k), {31'b0, oq[k]}, {31'b0, w1_out[k]});
    if (cq.size() == 8) begin
      chk("single_first_cyc", cq[0], e + 2);
      chk("single_last_cyc", cq[7], e + 9);
    end
    chk("single_last_cnt", lq.size(), 32'd1);
    if (lq.size() == 1) chk("single_last_idx", lq[0], 32'd7);
    chk("single_ovf", ovf, 32'd0);
    chk("single_stray_last", bad_last, 32'd0);

    // Ping-pong A(10), 1-cycle gap, B(12)
    clear_log();
    send_window(10, pa, ea);
    send_window(12, pb, eb);
    drain();
    chk("pp_count", oq.size(), 32'd22);
    check_window("pp_a", 0, 10, pa);
    check_window("pp_b", 10, 12, pb);
    if (cq.size() == 22) begin
      chk("pp_a_first_cyc", cq[0], ea + 2);
      chk("pp_b_first_cyc", cq[10], eb + 2);
    end
    chk("pp_last_cnt", lq.size(), 32'd2);
    if (lq.size() == 2) begin
      chk("pp_last_a", lq[0], 32'd9);
      chk("pp_last_b", lq[1], 32'd21);
    end
    chk("pp_ovf", ovf, 32'd0);

    // Bank overflow: DEPTH+3 bits
    clear_log();
    send_window(DEPTH + 3, po, e);
    drain();
    chk("bo_ovf", ovf, 32'd3);
    chk("bo_count", oq.size(), DEPTH);
    if (oq.size() == DEPTH) chk("bo_first_is_in63", {31'b0, oq[0]}, {31'b0, po[DEPTH-1]});
    check_window("bo", 0, DEPTH, po);
    chk("bo_last_cnt", lq.size(), 32'd1);

    // Blocked: W1(60), W2(4) fill both banks, W3(60) arrives while W1 still replays
    clear_log();
    send_window(60, p1, e);
    send_window(4, p2, e);
    send_window(60, p3, e);
    drain();
    chk("blk_ovf", ovf, 32'd60);
    chk("blk_count", oq.size(), 32'd64);
    check_window("blk_w1", 0, 60, p1);
    check_window("blk_w2", 60, 4, p2);
    if (cq.size() == 64) chk("blk_one_idle", cq[60], cq[59] + 2);
    chk("blk_last_cnt", lq.size(), 32'd2);
    if (lq.size() == 2) begin
      chk("blk_last_w1", lq[0], 32'd59);
      chk("blk_last_w2", lq[1], 32'd63);
    end
    chk("blk_stray_last", bad_last, 32'd0);

    // Mid-replay reset at the 3rd valid bit
    clear_log();
    send_window(8, pm, e);
    for (int i = 0; i < 50 && oq.size() < 3; i++) step();
    chk("mr_reached_3rd", oq.size(), 32'd3);
    rst = 1'b1;
    step();
    chk("mr_valid_after_rst", {31'b0, d_valid}, 32'd0);
    chk("mr_busy_after_rst", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("mr_no_residual", oq.size(), 32'd3);
    clear_log();
    send_window(6, 128'h2B, e);
    drain();
    chk("mr_count", oq.size(), 32'd6);
    check_window("mr_post", 0, 6, 128'h2B);
    if (cq.size() == 6) chk("mr_first_cyc", cq[0], e + 2);
    chk("mr_ovf", ovf, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
